// File: rtl/cart_bank_mapper_if.sv
// CPU-side and ROM/SRAM-store signals of the cartridge bank mapper.
// The master modport is the CPU/store side and the slave modport is the mapper.
interface cart_bank_mapper_if #(
  parameter int ROM_AW  = 25,
  parameter int SRAM_AW = 13
);
  logic [15:0]         addr;
  logic [7:0]          d_from_cpu;
  logic                wr;
  logic                rd;
  logic                cs;
  logic [2:0]          mode;
  logic [ROM_AW-1:0]   rom_size;
  logic [ROM_AW-1:0]   ram_addr;
  logic                ram_rd;
  logic                ram_ready;
  logic [7:0]          ram_dout;
  logic [SRAM_AW-1:0]  sram_addr;
  logic                sram_we;
  logic [7:0]          sram_q;
  logic [7:0]          d_to_cpu;
  logic                wait_n;

  modport master (
    output addr, d_from_cpu, wr, rd, cs, mode, rom_size, ram_ready, ram_dout, sram_q,
    input  ram_addr, ram_rd, sram_addr, sram_we, d_to_cpu, wait_n
  );

  modport slave (
    input  addr, d_from_cpu, wr, rd, cs, mode, rom_size, ram_ready, ram_dout, sram_q,
    output ram_addr, ram_rd, sram_addr, sram_we, d_to_cpu, wait_n
  );
endinterface

// File: rtl/cart_bank_mapper.sv
// Run-time selectable MSX cartridge mapper (plain/Konami/SCC/ASCII8/ASCII16):
// bank-register decode, ROM address translation, SRAM windows and wait-state reads.
module cart_bank_mapper #(
    parameter int ROM_AW  = 25,
    parameter int BANK_W  = 8,
    parameter int SRAM_AW = 13
) (
    input logic               clk,
    input logic               reset_n,
    cart_bank_mapper_if.slave bus
);
    typedef enum logic [2:0] {
        M_PLAIN   = 3'd0,
        M_KONAMI  = 3'd1,
        M_SCC     = 3'd2,
        M_ASCII8  = 3'd3,
        M_ASCII16 = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    logic [BANK_W-1:0] r_bank [4];
    logic [2:0]        r_mode_q;
    logic              r_wr_q;
    logic              r_sram_we;
    state_e            r_state;
    logic              r_ram_rd;
    logic              r_wait_n;
    logic [7:0]        r_data;

    mode_e             w_mode;
    logic              w_wr_edge;
    logic [2:0]        w_page;
    logic              w_in_win;
    logic [1:0]        w_win;
    logic [BANK_W-1:0] w_bank;
    logic              w_hit;
    logic              w_sram;
    logic              w_rom_hit;
    logic              w_bsel_v;
    logic [1:0]        w_bsel;
    logic [ROM_AW-1:0] w_raw_addr;

    assign w_mode    = (r_mode_q > 3'd4) ? M_PLAIN : mode_e'(r_mode_q);
    assign w_wr_edge = bus.cs & bus.wr & ~r_wr_q;
    assign w_page    = bus.addr[15:13];
    assign w_in_win  = (w_page >= 3'd2) && (w_page <= 3'd5);
    assign w_win     = 2'(w_page - 3'd2);

    always_comb begin
        w_bank = r_bank[w_win];
        if (w_mode == M_ASCII16) begin
            w_bank = w_win[1] ? r_bank[2] : r_bank[0];
        end
    end

    assign w_hit     = (w_mode == M_PLAIN) | w_in_win;
    assign w_sram    = ((w_mode == M_ASCII8) | (w_mode == M_ASCII16)) & w_in_win & w_bank[BANK_W-1];
    assign w_rom_hit = w_hit & ~w_sram;

    always_comb begin
        case (w_mode)
            M_PLAIN:   w_raw_addr = ROM_AW'(bus.addr);
            M_ASCII16: w_raw_addr = ROM_AW'({w_bank[BANK_W-2:0], bus.addr[13:0]});
            default:   w_raw_addr = ROM_AW'({w_bank[BANK_W-2:0], bus.addr[12:0]});
        endcase
    end

    assign bus.ram_addr  = w_raw_addr & (bus.rom_size - ROM_AW'(1));
    assign bus.sram_addr = bus.addr[SRAM_AW-1:0];
    assign bus.sram_we   = r_sram_we;
    assign bus.ram_rd    = r_ram_rd;
    assign bus.wait_n    = r_wait_n;
    assign bus.d_to_cpu  = !w_hit ? 8'hFF : (w_sram ? bus.sram_q : r_data);

    // Bank register select; SCC/ASCII decode on 2 KB slices (addr[15:11]).
    always_comb begin
        w_bsel_v = 1'b0;
        w_bsel   = '0;
        case (w_mode)
            M_KONAMI: begin
                w_bsel_v = (w_page >= 3'd3) && (w_page <= 3'd5);
                w_bsel   = w_win;
            end
            M_SCC: begin
                w_bsel_v = (bus.addr[12:11] == 2'b10) && (w_page >= 3'd2) && (w_page <= 3'd5);
                w_bsel   = w_win;
            end
            M_ASCII8: begin
                w_bsel_v = (bus.addr[15:13] == 3'b011);
                w_bsel   = bus.addr[12:11];
            end
            M_ASCII16: begin
                w_bsel_v = (bus.addr[15:13] == 3'b011) && !bus.addr[11];
                w_bsel   = {bus.addr[12], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank    <= '{default: '0};
            r_mode_q  <= '0;
            r_wr_q    <= 1'b0;
            r_sram_we <= 1'b0;
        end else begin
            r_wr_q    <= bus.wr;
            r_sram_we <= w_wr_edge & w_sram & w_win[1];
            // A mode change wins over any coincident bank write.
            if (bus.mode != r_mode_q) begin
                r_mode_q <= bus.mode;
                for (int unsigned i = 0; i < 4; i++) begin
                    r_bank[i] <= ((bus.mode == 3'd1) || (bus.mode == 3'd2)) ? BANK_W'(i) : '0;
                end
            end else if (w_wr_edge && w_bsel_v) begin
                r_bank[w_bsel] <= BANK_W'(bus.d_from_cpu);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ram_rd <= 1'b0;
            r_wait_n <= 1'b1;
            r_data   <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cs && bus.rd && w_rom_hit) begin
                        r_state  <= S_REQ;
                        r_ram_rd <= 1'b1;
                        r_wait_n <= 1'b0;
                    end
                end
                S_REQ: begin
                    r_state  <= S_WAIT;
                    r_ram_rd <= 1'b0;
                end
                S_WAIT: begin
                    if (bus.ram_ready) begin
                        r_state  <= S_HOLD;
                        r_data   <= bus.ram_dout;
                        r_wait_n <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!bus.rd) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cart_bank_mapper.sv
// Self-checking bench for cart_bank_mapper: directed spec scenarios plus
// randomized bank writes/reads checked against an arithmetic mapper model.
module tb_cart_bank_mapper;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cart_bank_mapper_if #(.ROM_AW(25), .SRAM_AW(13)) bus ();

    cart_bank_mapper #(.ROM_AW(25), .BANK_W(8), .SRAM_AW(13)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: bank values, effective mode, raw mode, image size.
    int mb[4];
    int mmode   = 0;
    int rawmode = 0;
    int rsize   = 32'h20000;

    function automatic bit m_in_win(int a);
        return (a >= 'h4000) && (a < 'hC000);
    endfunction

    function automatic int m_bank(int a);
        int w;
        w = (a - 'h4000) / 'h2000;
        if (mmode == 4) return (w < 2) ? mb[0] : mb[2];
        return mb[w];
    endfunction

    function automatic int exp_addr(int a);
        if (mmode == 0) return a % rsize;
        if (mmode == 4) return ((m_bank(a) % 128) * 16384 + a % 16384) % rsize;
        return ((m_bank(a) % 128) * 8192 + a % 8192) % rsize;
    endfunction

    function automatic bit m_is_sram(int a);
        return (mmode == 3 || mmode == 4) && m_in_win(a) && (m_bank(a) >= 128);
    endfunction

    function automatic void m_write(int a, int d);
        case (mmode)
            1: if (a >= 'h6000 && a < 'hC000) mb[(a - 'h4000) / 'h2000] = d;
            2: begin
                if (a >= 'h5000 && a < 'h5800) mb[0] = d;
                if (a >= 'h7000 && a < 'h7800) mb[1] = d;
                if (a >= 'h9000 && a < 'h9800) mb[2] = d;
                if (a >= 'hB000 && a < 'hB800) mb[3] = d;
            end
            3: if (a >= 'h6000 && a < 'h8000) mb[(a - 'h6000) / 'h800] = d;
            4: begin
                if (a >= 'h6000 && a < 'h6800) mb[0] = d;
                if (a >= 'h7000 && a < 'h7800) mb[2] = d;
            end
            default: ;
        endcase
    endfunction

    function automatic void m_set_mode(int m);
        rawmode = m;
        mmode   = (m > 4) ? 0 : m;
        for (int i = 0; i < 4; i++) mb[i] = (mmode == 1 || mmode == 2) ? i : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int a, input int d);
        bus.addr = 16'(a); bus.d_from_cpu = 8'(d); bus.cs = 1'b1; bus.wr = 1'b1;
        step();
        m_write(a, d);
        bus.wr = 1'b0;
        step();
        bus.cs = 1'b0;
    endtask

    task automatic set_mode(input int m);
        bus.mode = 3'(m);
        step();
        if (m != rawmode) m_set_mode(m);
    endtask

    task automatic set_size(input int s);
        rsize = s;
        bus.rom_size = 25'(s);
    endtask

    task automatic rom_read(input int a, input logic [7:0] data);
        bus.addr = 16'(a); bus.cs = 1'b1; bus.rd = 1'b1;
        #1;
        check("rd_addr", 32'(bus.ram_addr), exp_addr(a));
        check("rd_wait_pre", 32'(bus.wait_n), 1);
        step();
        check("rd_req_ram_rd", 32'(bus.ram_rd), 1);
        check("rd_req_wait", 32'(bus.wait_n), 0);
        bus.ram_ready = 1'b1; bus.ram_dout = 8'hEE;
        step();
        check("rd_wait_ram_rd", 32'(bus.ram_rd), 0);
        check("rd_ready_in_req_ignored", 32'(bus.wait_n), 0);
        bus.ram_ready = 1'b0;
        step();
        check("rd_wait_hold", 32'(bus.wait_n), 0);
        bus.ram_ready = 1'b1; bus.ram_dout = data;
        step();
        check("rd_done_wait", 32'(bus.wait_n), 1);
        check("rd_data", 32'(bus.d_to_cpu), 32'(data));
        bus.ram_ready = 1'b0; bus.rd = 1'b0;
        step();
        check("rd_idle_ram_rd", 32'(bus.ram_rd), 0);
        check("rd_idle_wait", 32'(bus.wait_n), 1);
        bus.cs = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                cpu_write('h4000 + $urandom_range(0, 'h7FFF), $urandom_range(0, 255));
            end else begin
                a = $urandom_range(0, 'hFFFF);
                bus.addr = 16'(a); bus.cs = 1'b1; bus.sram_q = 8'($urandom_range(0, 255));
                #1;
                if (mmode == 0 || m_in_win(a)) check("rnd_addr", 32'(bus.ram_addr), exp_addr(a));
                if (m_is_sram(a)) check("rnd_sram_q", 32'(bus.d_to_cpu), 32'(bus.sram_q));
                else if (mmode != 0 && !m_in_win(a)) check("rnd_miss_ff", 32'(bus.d_to_cpu), 'hFF);
                step();
                bus.cs = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bus.addr = '0; bus.d_from_cpu = '0; bus.wr = 1'b0; bus.rd = 1'b0; bus.cs = 1'b0;
        bus.mode = '0; bus.ram_ready = 1'b0; bus.ram_dout = '0; bus.sram_q = '0;
        set_size('h20000);
        m_set_mode(0);
        #22;
        check("rst_wait_n", 32'(bus.wait_n), 1);
        check("rst_ram_rd", 32'(bus.ram_rd), 0);
        check("rst_sram_we", 32'(bus.sram_we), 0);
        check("rst_d_to_cpu", 32'(bus.d_to_cpu), 'hFF);
        reset_n = 1'b1;
        step();
        bus.addr = 16'h1234; #1;
        check("plain_addr", 32'(bus.ram_addr), 'h1234);

        // Konami default bank read.
        set_mode(1);
        rom_read('h8000, 8'h5A);
        bus.addr = 16'h8000; #1;
        check("konami_8000", 32'(bus.ram_addr), 'h04000);
        rand_phase(40);

        // SCC.
        set_mode(2);
        cpu_write('h9000, 'h1F);
        bus.addr = 16'h8123; #1;
        check("scc_8123", 32'(bus.ram_addr), 'h1E123);
        rand_phase(40);

        // ASCII16 and wr held high.
        set_mode(4);
        cpu_write('h7000, 'h03);
        bus.addr = 16'hA456; #1;
        check("a16_A456", 32'(bus.ram_addr), 'h0E456);
        bus.addr = 16'h6000; bus.d_from_cpu = 8'h05; bus.cs = 1'b1; bus.wr = 1'b1;
        step();
        bus.d_from_cpu = 8'h06;
        repeat (4) step();
        bus.wr = 1'b0; step(); bus.cs = 1'b0;
        m_write('h6000, 'h05);
        bus.addr = 16'h4000; #1;
        check("a16_wr_held_once", 32'(bus.ram_addr), exp_addr('h4000));
        set_size('h80000);
        rand_phase(40);

        // ASCII8 with SRAM in W2.
        set_size('h20000);
        set_mode(3);
        cpu_write('h7000, 'h80);
        bus.addr = 16'h9010; bus.d_from_cpu = 8'h77; bus.cs = 1'b1; bus.wr = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.sram_we === 1'b1) cnt++;
        end
        check("sram_addr", 32'(bus.sram_addr), 'h1010);
        bus.wr = 1'b0; step();
        if (bus.sram_we === 1'b1) cnt++;
        check("sram_we_once", cnt, 1);
        bus.sram_q = 8'hC3; bus.rd = 1'b1; #1;
        check("sram_rd_data", 32'(bus.d_to_cpu), 'hC3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sram_rd_wait_n", 32'(bus.wait_n), 1);
            check("sram_rd_ram_rd", 32'(bus.ram_rd), 0);
        end
        bus.addr = 16'h2000; #1;
        check("miss_ff", 32'(bus.d_to_cpu), 'hFF);
        step();
        check("miss_no_ram_rd", 32'(bus.ram_rd), 0);
        bus.rd = 1'b0; bus.cs = 1'b0;
        set_size('h80000);
        rand_phase(40);

        // Mode change 1 -> 3 discards a coincident write.
        set_size('h20000);
        set_mode(1);
        cpu_write('hA000, 'h09);
        bus.addr = 16'hA000; #1;
        check("konami_b3", 32'(bus.ram_addr), 'h12000);
        bus.mode = 3'd3; bus.addr = 16'h6000; bus.d_from_cpu = 8'h44; bus.cs = 1'b1; bus.wr = 1'b1;
        step();
        m_set_mode(3);
        bus.wr = 1'b0; step(); bus.cs = 1'b0;
        for (int w = 0; w < 4; w++) begin
            bus.addr = 16'('h4123 + w * 'h2000); #1;
            check("modechg_bank0", 32'(bus.ram_addr), exp_addr('h4123 + w * 'h2000));
        end

        // Reset during WAIT.
        set_mode(1);
        bus.addr = 16'h8000; bus.cs = 1'b1; bus.rd = 1'b1;
        step(); step();
        check("pre_rst_wait", 32'(bus.wait_n), 0);
        reset_n = 1'b0; #1;
        check("rst_in_wait_wait_n", 32'(bus.wait_n), 1);
        check("rst_in_wait_ram_rd", 32'(bus.ram_rd), 0);
        bus.rd = 1'b0;
        step();
        reset_n = 1'b1;
        m_set_mode(0);
        bus.ram_ready = 1'b1; bus.ram_dout = 8'h99;
        step();
        m_set_mode(1);
        step();
        check("late_ready_wait_n", 32'(bus.wait_n), 1);
        check("late_ready_ram_rd", 32'(bus.ram_rd), 0);
        check("late_ready_no_latch", 32'(bus.d_to_cpu), 'hFF);
        bus.ram_ready = 1'b0; bus.cs = 1'b0;

        // Undefined mode behaves as plain.
        set_mode(5);
        bus.addr = 16'hF123; #1;
        check("mode5_plain", 32'(bus.ram_addr), exp_addr('hF123));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
